// File: rtl/blackjack_pkg.sv
// ----------------------------------------------------------------------------
// blackjack_pkg
// Constants and state encodings shared by the blackjack round sequencer and
// its card-request handshake engine.
//   HAND_W       : width of the hand totals from the card adder
//   BLACKJACK    : target total; anything above it is a bust
//   DEALER_STAND : dealer keeps drawing while the dealer total is below this
//   ACK_TIMEOUT  : cycles a request may wait for an acknowledge
// ----------------------------------------------------------------------------
package blackjack_pkg;

   localparam int HAND_W       = 6;
   localparam int BLACKJACK    = 21;
   localparam int DEALER_STAND = 17;
   localparam int ACK_TIMEOUT  = 32;
   localparam int TMO_W        = $clog2(ACK_TIMEOUT + 1);

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_DEAL_REQ,
      ST_DEAL_WAIT,
      ST_PLAYER_TURN,
      ST_HIT_WAIT,
      ST_DEALER_CHECK,
      ST_DEALER_WAIT,
      ST_COMPARE,
      ST_RESULT,
      ST_ERROR
   } round_state_t;

   typedef enum logic [1:0] {
      RQ_IDLE,
      RQ_REQ,
      RQ_RELEASE,
      RQ_SETTLE
   } req_state_t;

endpackage

// File: rtl/blackjack_round_ctrl_card_requester.sv
// ----------------------------------------------------------------------------
// card_requester
// One card request towards the card adder: raise the request, hold it until
// the acknowledge arrives, drop it, wait for the acknowledge to fall, then
// report completion one cycle later so the hand totals have settled.
// A request that is not acknowledged within ACK_TIMEOUT cycles is abandoned.
// Ports:
//   i_Clock, i_Reset_n : clock, asynchronous active-low reset
//   go                 : single-cycle start, accepted only when idle
//   to_dealer          : 0 = card to player, 1 = card to dealer
//   i_CardOK           : acknowledge from the card adder
//   o_Card2P, o_Card2D : registered request lines (never both high)
//   done               : single-cycle pulse, hands may now be evaluated
//   timeout            : single-cycle pulse, request abandoned
// ----------------------------------------------------------------------------
module card_requester
   import blackjack_pkg::*;
(
   input  logic i_Clock,
   input  logic i_Reset_n,
   input  logic go,
   input  logic to_dealer,
   input  logic i_CardOK,
   output logic o_Card2P,
   output logic o_Card2D,
   output logic done,
   output logic timeout
);

   // The request has been high for TMO_LAST+1 cycles when the counter
   // holds TMO_LAST, so that is the last cycle an acknowledge can rescue it.
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

   req_state_t       state_reg, state_next;
   logic [TMO_W-1:0] tmo_cnt_reg, tmo_cnt_next;
   logic             card_p_reg, card_p_next;
   logic             card_d_reg, card_d_next;

   always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         state_reg   <= RQ_IDLE;
         tmo_cnt_reg <= '0;
         card_p_reg  <= 1'b0;
         card_d_reg  <= 1'b0;
      end else begin
         state_reg   <= state_next;
         tmo_cnt_reg <= tmo_cnt_next;
         card_p_reg  <= card_p_next;
         card_d_reg  <= card_d_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      tmo_cnt_next = tmo_cnt_reg;
      card_p_next  = card_p_reg;
      card_d_next  = card_d_reg;
      done         = 1'b0;
      timeout      = 1'b0;
      case (state_reg)
         RQ_IDLE: begin
            if (go) begin
               state_next   = RQ_REQ;
               tmo_cnt_next = '0;
               card_p_next  = ~to_dealer;
               card_d_next  = to_dealer;
            end
         end
         RQ_REQ: begin
            if (i_CardOK) begin
               card_p_next = 1'b0;
               card_d_next = 1'b0;
               state_next  = RQ_RELEASE;
            end else if (tmo_cnt_reg >= TMO_LAST) begin
               card_p_next = 1'b0;
               card_d_next = 1'b0;
               timeout     = 1'b1;
               state_next  = RQ_IDLE;
            end else begin
               tmo_cnt_next = tmo_cnt_reg + TMO_W'(1);
            end
         end
         RQ_RELEASE: begin
            if (!i_CardOK) begin
               state_next = RQ_SETTLE;
            end
         end
         RQ_SETTLE: begin
            done       = 1'b1;
            state_next = RQ_IDLE;
         end
         default: begin
            state_next = RQ_IDLE;
         end
      endcase
   end

   assign o_Card2P = card_p_reg;
   assign o_Card2D = card_d_reg;

endmodule

// File: rtl/blackjack_round_ctrl.sv
// ----------------------------------------------------------------------------
// blackjack_round_ctrl
// Round sequencer for the card-adder stage: clears the adder, deals P,D,P,D,
// runs the player's hit/stay turn and the dealer's draw-to-17 rule, compares
// the hands and latches Win / Lose / Tie (or Error on an ack timeout).
// Ports:
//   i_Clock, i_Reset_n        : clock, asynchronous active-low reset
//   i_Start, i_Hit, i_Stay    : level inputs, acted on at their rising edge
//   i_CardOK                  : card-adder acknowledge
//   i_PlayerHnd, i_DealerHnd  : hand totals from the card adder
//   o_Card2P, o_Card2D        : registered card requests
//   o_AdderReset              : two-cycle clear of the card adder
//   o_PlayerTurn              : waiting for the player's hit/stay
//   o_Win, o_Lose, o_Tie      : latched round result
//   o_Error                   : latched acknowledge timeout
// ----------------------------------------------------------------------------
module blackjack_round_ctrl
   import blackjack_pkg::*;
(
   input  logic              i_Clock,
   input  logic              i_Reset_n,
   input  logic              i_Start,
   input  logic              i_Hit,
   input  logic              i_Stay,
   input  logic              i_CardOK,
   input  logic [HAND_W-1:0] i_PlayerHnd,
   input  logic [HAND_W-1:0] i_DealerHnd,
   output logic              o_Card2P,
   output logic              o_Card2D,
   output logic              o_AdderReset,
   output logic              o_PlayerTurn,
   output logic              o_Win,
   output logic              o_Lose,
   output logic              o_Tie,
   output logic              o_Error
);

   localparam logic [HAND_W-1:0] BJ_VAL    = HAND_W'(BLACKJACK);
   localparam logic [HAND_W-1:0] STAND_VAL = HAND_W'(DEALER_STAND);

   round_state_t state_reg, state_next;
   logic         start_q_reg, hit_q_reg, stay_q_reg;
   logic         start_evt, hit_evt, stay_evt;
   logic [1:0]   deal_cnt_reg, deal_cnt_next;
   logic         clr_cnt_reg, clr_cnt_next;
   logic         win_reg, win_next;
   logic         lose_reg, lose_next;
   logic         tie_reg, tie_next;
   logic         error_reg, error_next;
   logic         req_go, req_to_dealer, req_done, req_timeout;

   assign start_evt = i_Start & ~start_q_reg;
   assign hit_evt   = i_Hit   & ~hit_q_reg;
   assign stay_evt  = i_Stay  & ~stay_q_reg;

   always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         state_reg    <= ST_IDLE;
         start_q_reg  <= 1'b0;
         hit_q_reg    <= 1'b0;
         stay_q_reg   <= 1'b0;
         deal_cnt_reg <= 2'd0;
         clr_cnt_reg  <= 1'b0;
         win_reg      <= 1'b0;
         lose_reg     <= 1'b0;
         tie_reg      <= 1'b0;
         error_reg    <= 1'b0;
      end else begin
         state_reg    <= state_next;
         start_q_reg  <= i_Start;
         hit_q_reg    <= i_Hit;
         stay_q_reg   <= i_Stay;
         deal_cnt_reg <= deal_cnt_next;
         clr_cnt_reg  <= clr_cnt_next;
         win_reg      <= win_next;
         lose_reg     <= lose_next;
         tie_reg      <= tie_next;
         error_reg    <= error_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      deal_cnt_next = deal_cnt_reg;
      clr_cnt_next  = clr_cnt_reg;
      win_next      = win_reg;
      lose_next     = lose_reg;
      tie_next      = tie_reg;
      error_next    = error_reg;
      req_go        = 1'b0;
      req_to_dealer = 1'b0;
      case (state_reg)
         ST_IDLE, ST_RESULT, ST_ERROR: begin
            if (start_evt) begin
               state_next    = ST_CLEAR;
               deal_cnt_next = 2'd0;
               clr_cnt_next  = 1'b0;
               win_next      = 1'b0;
               lose_next     = 1'b0;
               tie_next      = 1'b0;
               error_next    = 1'b0;
            end
         end
         ST_CLEAR: begin
            // Second cycle of the adder clear ends here.
            if (clr_cnt_reg) begin
               state_next = ST_DEAL_REQ;
            end else begin
               clr_cnt_next = 1'b1;
            end
         end
         ST_DEAL_REQ: begin
            req_go        = 1'b1;
            req_to_dealer = deal_cnt_reg[0];
            state_next    = ST_DEAL_WAIT;
         end
         ST_DEAL_WAIT: begin
            if (req_timeout) begin
               error_next = 1'b1;
               state_next = ST_ERROR;
            end else if (req_done) begin
               if (deal_cnt_reg == 2'd3) begin
                  if (i_PlayerHnd == BJ_VAL) begin
                     // Natural blackjack: no player turn, dealer does not draw.
                     tie_next   = (i_DealerHnd == BJ_VAL);
                     win_next   = (i_DealerHnd != BJ_VAL);
                     state_next = ST_RESULT;
                  end else begin
                     state_next = ST_PLAYER_TURN;
                  end
               end else begin
                  deal_cnt_next = deal_cnt_reg + 2'd1;
                  state_next    = ST_DEAL_REQ;
               end
            end
         end
         ST_PLAYER_TURN: begin
            // Stay takes priority over a simultaneous hit.
            if (stay_evt) begin
               state_next = ST_DEALER_CHECK;
            end else if (hit_evt) begin
               req_go     = 1'b1;
               state_next = ST_HIT_WAIT;
            end
         end
         ST_HIT_WAIT: begin
            if (req_timeout) begin
               error_next = 1'b1;
               state_next = ST_ERROR;
            end else if (req_done) begin
               if (i_PlayerHnd > BJ_VAL) begin
                  lose_next  = 1'b1;
                  state_next = ST_RESULT;
               end else if (i_PlayerHnd == BJ_VAL) begin
                  state_next = ST_DEALER_CHECK;
               end else begin
                  state_next = ST_PLAYER_TURN;
               end
            end
         end
         ST_DEALER_CHECK: begin
            if (i_DealerHnd < STAND_VAL) begin
               req_go        = 1'b1;
               req_to_dealer = 1'b1;
               state_next    = ST_DEALER_WAIT;
            end else begin
               state_next = ST_COMPARE;
            end
         end
         ST_DEALER_WAIT: begin
            if (req_timeout) begin
               error_next = 1'b1;
               state_next = ST_ERROR;
            end else if (req_done) begin
               state_next = ST_DEALER_CHECK;
            end
         end
         ST_COMPARE: begin
            if (i_DealerHnd > BJ_VAL) begin
               win_next = 1'b1;
            end else if (i_PlayerHnd > i_DealerHnd) begin
               win_next = 1'b1;
            end else if (i_PlayerHnd == i_DealerHnd) begin
               tie_next = 1'b1;
            end else begin
               lose_next = 1'b1;
            end
            state_next = ST_RESULT;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   card_requester u_card_requester (
      .i_Clock   (i_Clock),
      .i_Reset_n (i_Reset_n),
      .go        (req_go),
      .to_dealer (req_to_dealer),
      .i_CardOK  (i_CardOK),
      .o_Card2P  (o_Card2P),
      .o_Card2D  (o_Card2D),
      .done      (req_done),
      .timeout   (req_timeout)
   );

   assign o_AdderReset = (state_reg == ST_CLEAR);
   assign o_PlayerTurn = (state_reg == ST_PLAYER_TURN);
   assign o_Win        = win_reg;
   assign o_Lose       = lose_reg;
   assign o_Tie        = tie_reg;
   assign o_Error      = error_reg;

endmodule

// File: doc/blackjack_round_ctrl.md
Name: blackjack_round_ctrl

Overview:
Round sequencer that drives the card-adder stage. It issues player and dealer card requests and waits for each acknowledge. It runs the initial deal, the player's hit/stay turn and the dealer's draw-to-17 rule, then compares the two 6-bit hand totals and latches Win, Lose or Tie for the display stage.

Parameters:
HAND_W, 6, width of hand totals
BLACKJACK, 21, target / bust threshold
DEALER_STAND, 17, dealer stops drawing at hand >= this
ACK_TIMEOUT, 32, max cycles waiting for i_CardOK before error (deck exhausted)

Ports:
i_Clock  in  1  system clock
i_Reset_n  in  1  asynchronous reset, active-low
i_Start  in  1  level; rising edge starts a new round
i_Hit  in  1  debounced player button, level; rising edge = hit
i_Stay  in  1  debounced player button, level; rising edge = stay
i_CardOK  in  1  card-adder acknowledge, held while request held
i_PlayerHnd  in  HAND_W  player total from card adder
i_DealerHnd  in  HAND_W  dealer total from card adder
o_Card2P  out  1  request card to player (registered)
o_Card2D  out  1  request card to dealer (registered)
o_AdderReset  out  1  synchronous active-high clear for card adder
o_PlayerTurn  out  1  high while waiting for hit/stay
o_Win  out  1  latched result
o_Lose  out  1  latched result
o_Tie  out  1  latched result
o_Error  out  1  latched ack timeout

Behaviour:
- Async reset: all outputs 0; state IDLE; edge-detect registers, deal counter and timeout counter cleared.
- Edge detect: one register each on i_Start, i_Hit, i_Stay. Events are single-cycle internal pulses.
- IDLE / RESULT / ERROR: a Start edge goes to CLEAR, clears o_Win/o_Lose/o_Tie/o_Error and sets the deal counter to 0. Start edges in any other state are ignored.
- CLEAR: o_AdderReset=1 for exactly 2 cycles, then DEAL.
- Request handshake (every card):
  - REQ: raise o_Card2P or o_Card2D and hold it until i_CardOK=1.
  - Then drop the request the next cycle and enter RELEASE.
  - RELEASE: wait for i_CardOK=0, then evaluate one cycle later (hands are stable).
  - Never two requests high at once. A new request only starts after i_CardOK has been observed low.
- Timeout: the counter counts cycles in REQ. When it reaches ACK_TIMEOUT with no i_CardOK: drop the request, set o_Error=1, go to ERROR. The counter clears on every new REQ.
- DEAL: the counter is 0..3. Even values go to the player, odd values to the dealer (order P,D,P,D). After the 4th card:
  - player==BLACKJACK → RESULT: Tie if dealer==BLACKJACK, else Win.
  - Otherwise → PLAYER_TURN.
- PLAYER_TURN: o_PlayerTurn=1.
  - Stay edge → DEALER_CHECK.
  - Hit edge → player request.
  - If Hit and Stay edges arrive in the same cycle, Stay wins.
  - Edges in any other state are ignored.
- After a hit:
  - player > BLACKJACK → RESULT Lose; the dealer does not draw.
  - player == BLACKJACK → DEALER_CHECK (auto-stand).
  - Otherwise → PLAYER_TURN.
- DEALER_CHECK: dealer < DEALER_STAND → dealer request, then back to DEALER_CHECK. Otherwise → COMPARE.
- COMPARE (unsigned HAND_W compare), decided in this order:
  1. dealer > BLACKJACK → Win.
  2. player > dealer → Win.
  3. player == dealer → Tie.
  4. Otherwise → Lose.
- RESULT: exactly one of Win/Lose/Tie is high and held until the next Start edge or reset.
- Reset mid-handshake: requests drop immediately (async). The card adder is cleared via CLEAR on the next round.
- Arithmetic: compares only, no adders on hand values. The deal counter is 2 bits. The timeout counter is clog2(ACK_TIMEOUT+1) bits and saturating.

Decomposition:
- Shared package blackjack_pkg: state encoding constants for this FSM, BLACKJACK=21, DEALER_STAND=17, HAND_W=6.
- One sub-module, card_requester: req/ack/release handshake plus timeout counter.
  - Inputs: go, to_dealer, i_CardOK.
  - Outputs: o_Card2P, o_Card2D, done pulse, timeout pulse.
  - Instantiated once and shared by the deal, hit and dealer phases.

Test Plan:
- Bench uses a behavioural card-adder model (ack 3 cycles after request, held until request drops), scripted card values, and a Start edge for each round.
- Deal 10,9 / 7,8 (P=19, D=15):
  - Requests appear in order P,D,P,D, each ≥1 cycle apart with ack low between.
  - Ends with o_PlayerTurn=1.
- Same deal, then Stay:
  - Dealer draws 5 → D=20; no further request (20 ≥ 17).
  - o_Lose=1, Win=Tie=0.
- P=13, then Hit drawing 10 → 23:
  - o_Lose=1 one evaluation after release.
  - Zero dealer requests after the hit.
- Deal P=A+K=21, D=10+6:
  - o_Win=1 with no player turn; o_PlayerTurn never asserted.
  - Repeat with D=21: o_Tie=1.
- Hit and Stay rising in the same cycle:
  - Treated as Stay; no player request is issued.
- Model never acks:
  - o_Card2P drops after ACK_TIMEOUT=32 cycles; o_Error=1.
  - A later Start edge clears o_Error and pulses o_AdderReset for 2 cycles.
- Assert i_Reset_n low while o_Card2D=1:
  - All outputs 0 in the same cycle (async); state IDLE after release.
